// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte arbiter with per-requester lock in front of a shared UART TX engine.
// Sequences the engine load/ready handshake and raises a sticky flag if the engine never accepts a load.
module uart_tx_arbiter #(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int TO_CYC = 1000
) (
    input  logic            clk100mhz,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    lock,
    input  logic [N*DW-1:0] data_in,
    output logic [N-1:0]    ack,
    output logic [2:0]      grant_id,
    output logic            busy,
    input  logic            tx_rdy,
    output logic            tx_load,
    output logic [DW-1:0]   tx_out,
    output logic            err_timeout
);
    localparam int CW = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_LO, WAIT_HI} state_t;

    state_t          state_q, state_d;
    logic [2:0]      rr_q, rr_d, cur_q, cur_d, grant_q, grant_d;
    logic [N-1:0]    ack_q, ack_d;
    logic            load_q, load_d, err_q, err_d;
    logic [DW-1:0]   out_q, out_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot, held;
    logic [2:0]      off, win, gid;
    logic [3:0]      sum;
    logic            hit, relock, go;

    function automatic logic [2:0] inc(input logic [2:0] v);
        return (v == 3'(N - 1)) ? 3'd0 : v + 3'd1;
    endfunction

    // Rotate requests so bit 0 is rr_q, then take the lowest set offset.
    always_comb begin
        dbl = {req, req} >> rr_q;
        rot = dbl[N-1:0];
        off = 3'd0;
        hit = |rot;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) off = 3'(i);
        sum = 4'(rr_q) + 4'(off);
        win = (sum >= 4'(N)) ? 3'(sum - 4'(N)) : sum[2:0];
    end

    assign held   = (req & lock) >> cur_q;
    assign relock = held[0];
    assign go     = tx_rdy && ((state_q == IDLE && hit) || (state_q == WAIT_HI && relock));
    assign gid    = (state_q == WAIT_HI) ? cur_q : win;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cur_d   = cur_q;
        grant_d = grant_q;
        out_d   = out_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        load_d  = 1'b0;
        case (state_q)
            LOAD: begin
                state_d = WAIT_LO;
                cnt_d   = '0;
            end
            WAIT_LO: begin
                if (!tx_rdy) begin
                    state_d = WAIT_HI;
                end else if (cnt_q == CW'(TO_CYC - 1)) begin
                    err_d   = 1'b1;
                    rr_d    = inc(cur_q);
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_HI: begin
                if (tx_rdy && !relock) begin
                    rr_d    = inc(cur_q);
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
        if (go) begin
            state_d = LOAD;
            cur_d   = gid;
            grant_d = gid;
            out_d   = data_in[int'(gid)*DW +: DW];
            ack_d   = {{(N-1){1'b0}}, 1'b1} << gid;
            load_d  = 1'b1;
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            cur_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            load_q  <= 1'b0;
            out_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cur_q   <= cur_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            load_q  <= load_d;
            out_q   <= out_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack         = ack_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);
    assign tx_load     = load_q;
    assign tx_out      = out_q;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of grant order, lock bursts, handshake, timeout and reset abort.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 20;

    logic          clk, reset, tx_rdy, tx_load, busy, err_timeout;
    logic [N-1:0]  req, lock, ack;
    logic [N*DW-1:0] data_in;
    logic [2:0]    grant_id;
    logic [DW-1:0] tx_out;
    logic          eng_en, eng_rdy, man_rdy;
    int            frame;
    int            n_chk, n_fail;
    int            qid[$];
    logic [7:0]    qdat[$];

    uart_tx_arbiter #(.N(N), .DW(DW), .TO_CYC(TO)) dut (
        .clk100mhz(clk), .reset(reset), .req(req), .lock(lock), .data_in(data_in),
        .ack(ack), .grant_id(grant_id), .busy(busy), .tx_rdy(tx_rdy),
        .tx_load(tx_load), .tx_out(tx_out), .err_timeout(err_timeout)
    );

    assign tx_rdy = eng_en ? eng_rdy : man_rdy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic wait_acks(input string tag, input int n);
        for (int c = 0; c < 1000 && qid.size() < n; c++) tick;
        check(tag, qid.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 1000 && busy; c++) tick;
        check(tag, busy, 0);
    endtask

    task automatic clear_q;
        qid.delete();
        qdat.delete();
    endtask

    // Engine model: drop ready 3 cycles after a load, hold it low for a frame.
    initial begin
        eng_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (eng_en && tx_load) begin
                repeat (3) @(posedge clk);
                #1 eng_rdy = 1'b0;
                repeat (frame) @(posedge clk);
                #1 eng_rdy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (|ack) begin
            check("ack_onehot", $countones(ack), 1);
            check("ack_with_load", tx_load, 1);
            for (int i = 0; i < N; i++)
                if (ack[i]) qid.push_back(i);
            qdat.push_back(tx_out);
        end
    end

    initial begin
        int   ids[5];
        int   dat[5];
        int   handled, cnt1, k, id;
        bit   seen_lo, quiet;
        n_chk = 0; n_fail = 0;
        req = '0; lock = '0; data_in = '0;
        eng_en = 1'b0; man_rdy = 1'b1; frame = 100; reset = 1'b0;
        reset_dut;
        check("rst_ack", ack, 0);
        check("rst_grant", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_load", tx_load, 0);
        check("rst_out", tx_out, 0);
        check("rst_err", err_timeout, 0);

        eng_en = 1'b1;
        data_in[2*DW +: DW] = 8'h41;
        req = 4'b0100;
        tick;
        check("single_ack", ack, 4'b0100);
        check("single_load", tx_load, 1);
        check("single_out", tx_out, 8'h41);
        check("single_grant", grant_id, 2);
        req = '0;
        seen_lo = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick;
            if (!tx_rdy) seen_lo = 1'b1;
            if (seen_lo && tx_rdy) break;
        end
        check("single_frame", seen_lo && tx_rdy, 1);
        check("single_busy_hold", busy, 1);
        tick;
        check("single_busy_fall", busy, 0);

        frame = 10;
        reset_dut;
        clear_q;
        for (int i = 0; i < N; i++) data_in[i*DW +: DW] = 8'(8'h10 + 8'h11 * i);
        req = 4'b1111;
        for (int c = 0; c < 1000 && qid.size() < 5; c++) tick;
        req = '0;
        check("rr_count", qid.size(), 5);
        wait_idle("rr_idle");
        ids = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5 && i < qid.size(); i++) begin
            check("rr_id", qid[i], ids[i]);
            check("rr_data", qdat[i], 8'(8'h10 + 8'h11 * ids[i]));
        end

        reset_dut;
        clear_q;
        req = 4'b1010;
        for (int c = 0; c < 1000 && qid.size() < 3; c++) tick;
        req = '0;
        check("rr2_count", qid.size(), 3);
        wait_idle("rr2_idle");
        ids[0:2] = '{1, 3, 1};
        for (int i = 0; i < 3 && i < qid.size(); i++) check("rr2_id", qid[i], ids[i]);

        reset_dut;
        clear_q;
        req = 4'b0001;
        wait_acks("lock_pre", 1);
        req = '0;
        wait_idle("lock_pre_idle");
        clear_q;
        data_in[1*DW +: DW] = 8'hA0;
        req = 4'b1011;
        lock = 4'b0010;
        handled = 0; cnt1 = 0;
        for (int c = 0; c < 1500 && handled < 5; c++) begin
            tick;
            while (handled < qid.size()) begin
                id = qid[handled];
                handled++;
                if (id == 1) begin
                    cnt1++;
                    data_in[1*DW +: DW] = 8'(8'hA0 + cnt1);
                    if (cnt1 == 3) begin
                        req[1] = 1'b0;
                        lock[1] = 1'b0;
                    end
                end else begin
                    req[id] = 1'b0;
                end
            end
        end
        req = '0; lock = '0;
        check("lock_count", qid.size(), 5);
        wait_idle("lock_idle");
        ids = '{1, 1, 1, 3, 0};
        dat = '{8'hA0, 8'hA1, 8'hA2, 8'h43, 8'h10};
        for (int i = 0; i < 5 && i < qid.size(); i++) begin
            check("lock_id", qid[i], ids[i]);
            check("lock_data", qdat[i], dat[i]);
        end

        eng_en = 1'b0;
        man_rdy = 1'b0;
        req = 4'b0001;
        quiet = 1'b0;
        repeat (50) begin
            tick;
            quiet |= busy | (|ack);
        end
        check("nrdy_quiet", quiet, 0);
        man_rdy = 1'b1;
        tick;
        check("nrdy_ack", ack, 4'b0001);
        check("nrdy_load", tx_load, 1);
        req = '0;
        man_rdy = 1'b0;
        tick;
        tick;
        man_rdy = 1'b1;
        wait_idle("nrdy_idle");

        req = 4'b0100;
        tick;
        check("to_ack", ack, 4'b0100);
        req = '0;
        k = 0;
        for (int c = 1; c <= TO + 5; c++) begin
            tick;
            if (err_timeout) begin
                k = c;
                break;
            end
        end
        check("to_latency", k, TO + 1);
        check("to_idle", busy, 0);
        req = 4'b0011;
        tick;
        check("to_rr_adv", ack, 4'b0001);
        check("to_sticky", err_timeout, 1);
        req = '0;
        man_rdy = 1'b0;
        tick;
        tick;
        man_rdy = 1'b1;
        wait_idle("to_serve_idle");
        check("to_sticky2", err_timeout, 1);

        eng_en = 1'b1;
        frame = 30;
        clear_q;
        req = 4'b0100;
        wait_acks("mid_ack", 1);
        req = '0;
        for (int c = 0; c < 20 && tx_rdy; c++) tick;
        repeat (5) tick;
        check("mid_in_frame", busy, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mid_ack0", ack, 0);
        check("mid_load0", tx_load, 0);
        check("mid_busy0", busy, 0);
        check("mid_grant0", grant_id, 0);
        check("mid_out0", tx_out, 0);
        check("mid_err0", err_timeout, 0);
        tick;
        check("mid_noack", ack, 0);
        check("mid_nobusy", busy, 0);
        clear_q;
        req = 4'b1010;
        wait_acks("mid_regrant", 1);
        req = '0;
        check("mid_rr0", grant_id, 1);
        wait_idle("mid_idle1");
        clear_q;
        req = 4'b1000;
        wait_acks("mid_req3", 1);
        req = '0;
        check("mid_grant3", grant_id, 3);
        wait_idle("mid_idle2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
